// File: rtl/seconds_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seconds_tick_gen                                             |
// | Description : Stopwatch front end. Prescales clk to a 1 s tick, keeps a    |
// |               0..59 seconds count, emits a minute-carry pulse (sec_count)  |
// |               and a registered copy of clear (clr_out).                    |
// |               Build option: define SECONDS_BCD_EN for packed-BCD seconds.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seconds_tick_gen #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [7:0] seconds,
    output logic       sec_count,
    output logic       clr_out,
    output logic       running
);

    localparam int              PS_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0] c_PS_MAX = PS_W'(CLK_DIV - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_PAUSE = 2'd2;

`ifdef SECONDS_BCD_EN
    localparam logic [7:0] c_SEC_MAX = 8'h59;
`else
    localparam logic [7:0] c_SEC_MAX = 8'd59;
`endif

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [PS_W-1:0] r_prescaler;
    logic [7:0]      r_seconds;
    logic [7:0]      w_seconds_inc;
    logic            r_sec_count;
    logic            r_clr_out;
    logic            w_tick;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: clear beats stop, stop beats start
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (start && !stop) w_state_next = c_ST_RUN;
            c_ST_RUN:   if (stop)           w_state_next = c_ST_PAUSE;
            c_ST_PAUSE: if (start && !stop) w_state_next = c_ST_RUN;
            default:                        w_state_next = c_ST_IDLE;
        endcase
        if (clear) begin
            w_state_next = c_ST_IDLE;
        end
    end

    // Output decode: running follows the state register; tick on last prescaler count in RUN
    always_comb begin
        running = (r_state == c_ST_RUN);
        w_tick  = (r_state == c_ST_RUN) && (r_prescaler == c_PS_MAX);
    end

    // Seconds successor value, wrapping 59 -> 0 in the selected number format
    always_comb begin
        w_seconds_inc = 8'd0;
`ifdef SECONDS_BCD_EN
        if (r_seconds == c_SEC_MAX) begin
            w_seconds_inc = 8'h00;
        end else if (r_seconds[3:0] == 4'd9) begin
            w_seconds_inc = {r_seconds[7:4] + 4'd1, 4'd0};
        end else begin
            w_seconds_inc = {r_seconds[7:4], r_seconds[3:0] + 4'd1};
        end
`else
        if (r_seconds == c_SEC_MAX) begin
            w_seconds_inc = 8'd0;
        end else begin
            w_seconds_inc = r_seconds + 8'd1;
        end
`endif
    end

    // Prescaler: counts in RUN (including the stop edge), holds in PAUSE, zero in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescaler <= '0;
        end else if (clear) begin
            r_prescaler <= '0;
        end else begin
            case (r_state)
                c_ST_RUN:   r_prescaler <= w_tick ? '0 : r_prescaler + PS_W'(1);
                c_ST_PAUSE: r_prescaler <= r_prescaler;
                default:    r_prescaler <= '0;
            endcase
        end
    end

    // Seconds counter advances on each tick; clear wins over a coincident tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seconds <= 8'd0;
        end else if (clear) begin
            r_seconds <= 8'd0;
        end else if (w_tick) begin
            r_seconds <= w_seconds_inc;
        end
    end

    // Minute carry: one cycle, coincident with seconds returning to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec_count <= 1'b0;
        end else begin
            r_sec_count <= w_tick && !clear && (r_seconds == c_SEC_MAX);
        end
    end

    // Registered copy of clear for the downstream minutes counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr_out <= 1'b0;
        end else begin
            r_clr_out <= clear;
        end
    end

    assign seconds   = r_seconds;
    assign sec_count = r_sec_count;
    assign clr_out   = r_clr_out;

endmodule
`default_nettype wire

// File: tb/tb_seconds_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seconds_tick_gen                                          |
// | Description : Scoreboard bench for seconds_tick_gen (CLK_DIV = 4).         |
// |               Reference model tracks elapsed RUN cycles since the last     |
// |               clear/reset and derives seconds and carry arithmetically.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seconds_tick_gen;

    localparam int CLK_DIV = 4;
    localparam int WRAP    = 60 * CLK_DIV;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] seconds;
    logic       sec_count;
    logic       clr_out;
    logic       running;

    seconds_tick_gen #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .seconds   (seconds),
        .sec_count (sec_count),
        .clr_out   (clr_out),
        .running   (running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sec;
        logic       carry;
        logic       clr;
        logic       run;
    } exp_t;

    exp_t q[$];
    int   n_vec     = 0;
    int   n_err     = 0;
    int   m_elapsed = 0;
    int   m_mode    = M_IDLE;

    // Seconds value in the output number format
    function automatic logic [7:0] enc(input int s);
`ifdef SECONDS_BCD_EN
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(s / 10);
        u = 4'(s % 10);
        return {t, u};
`else
        return 8'(s);
`endif
    endfunction

    // Predict the outputs after the coming clock edge and queue them
    task automatic model_edge(input bit s, input bit p, input bit c);
        exp_t e;
        bit   carry;
        carry = 1'b0;
        if (c) begin
            m_elapsed = 0;
            m_mode    = M_IDLE;
        end else begin
            if (m_mode == M_RUN) begin
                m_elapsed = (m_elapsed + 1) % WRAP;
                carry     = (m_elapsed == 0);
            end
            if (p) begin
                if (m_mode == M_RUN) m_mode = M_PAUSE;
            end else if (s) begin
                m_mode = M_RUN;
            end
        end
        e.sec   = enc(m_elapsed / CLK_DIV);
        e.carry = carry;
        e.clr   = c;
        e.run   = (m_mode == M_RUN);
        q.push_back(e);
    endtask

    task automatic drive(input bit s, input bit p, input bit c);
        @(negedge clk);
        #1;
        rst   = 1'b0;
        start = s;
        stop  = p;
        clear = c;
        model_edge(s, p, c);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic hold_reset();
        @(negedge clk);
        #1;
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        clear     = 1'b0;
        m_elapsed = 0;
        m_mode    = M_IDLE;
        q.push_back('0);
    endtask

    // Reset between edges: outputs must be zero at the next negedge with no posedge in between
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        clear     = 1'b0;
        m_elapsed = 0;
        m_mode    = M_IDLE;
        if (q.size() > 0) void'(q.pop_back());
        q.push_back('0);
    endtask

    task automatic run_until(input int target);
        int k;
        k = 0;
        while (m_elapsed != target && k < 2 * WRAP) begin
            drive(1'b0, 1'b0, 1'b0);
            k++;
        end
        if (m_elapsed != target) begin
            n_err++;
            $display("FAIL run_until timeout: elapsed=%0d required=%0d", m_elapsed, target);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if ({seconds, sec_count, clr_out, running} !== e) begin
                    n_err++;
                    $display("FAIL outputs t=%0t: got seconds=%h sec_count=%b clr_out=%b running=%b, expected seconds=%h sec_count=%b clr_out=%b running=%b",
                             $time, seconds, sec_count, clr_out, running, e.sec, e.carry, e.clr, e.run);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int tgt;
        bit s;
        bit p;
        bit c;

        repeat (3) hold_reset();

        // Start, run a full minute plus a bit: 0..59 then carry on wrap
        drive(1'b1, 1'b0, 1'b0);
        idle(250);

        // Pause with prescaler at 2, idle, resume completes the partial second
        tgt = (((m_elapsed / CLK_DIV) + 1) * CLK_DIV + 1) % WRAP;
        run_until(tgt);
        drive(1'b0, 1'b1, 1'b0);
        idle(10);
        drive(1'b1, 1'b0, 1'b0);
        idle(8);

        // Clear coincident with the 59 -> 0 tick
        run_until(WRAP - 1);
        drive(1'b0, 1'b0, 1'b1);
        idle(3);

        // start+stop together: pause from RUN, stay put in PAUSE and IDLE
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        idle(20);
        drive(1'b1, 1'b1, 1'b0);
        idle(5);
        drive(1'b1, 1'b1, 1'b0);
        idle(3);
        drive(1'b1, 1'b0, 1'b0);
        idle(10);

        // Asynchronous reset mid-RUN at seconds=37, then restart from zero
        run_until(37 * CLK_DIV + 1);
        async_reset();
        hold_reset();
        drive(1'b1, 1'b0, 1'b0);
        idle(50);

        // Random pulses
        repeat (3000) begin
            s = ($urandom_range(0, 99) < 8);
            p = ($urandom_range(0, 99) < 4);
            c = ($urandom_range(0, 499) < 2);
            drive(s, p, c);
        end

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
